// File: rtl/sum_accumulator_pkg.sv
// Shared types, default widths and helpers for the sum accumulator.
package sum_accumulator_pkg;

  localparam int unsigned SUM_WIDTH_DEF = 61;
  localparam int unsigned ACC_WIDTH_DEF = 64;
  localparam int unsigned LEN_WIDTH_DEF = 8;

  // Widest frame-length field the helper supports.
  localparam int unsigned LEN_MAX = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // A frame length of zero means 2^lw samples; any other value is used as-is.
  function automatic logic [LEN_MAX:0] len_to_target(input logic [LEN_MAX-1:0] len,
                                                     input int unsigned      lw);
    if (len == '0) begin
      return {{LEN_MAX{1'b0}}, 1'b1} << lw;
    end
    return {1'b0, len};
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Sample counter for one frame: loads on the first sample, latches the
// frame target, and flags the sample that completes the frame.
module frame_counter
  import sum_accumulator_pkg::*;
#(
  parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 inc_i,
  input  logic                 clear_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic [LEN_WIDTH:0]   count_o,
  output logic                 last_o
);

  localparam int unsigned CW = LEN_WIDTH + 1;

  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] target_q, target_d;
  logic [CW-1:0] new_target;

  // Next count/target and terminal-count detection for the current accept.
  always_comb begin
    new_target = CW'(len_to_target(LEN_MAX'(len_i), LEN_WIDTH));
    count_d    = count_q;
    target_d   = target_q;
    last_o     = 1'b0;
    if (start_i) begin
      count_d  = CW'(1);
      target_d = new_target;
      last_o   = (new_target == CW'(1));
    end else if (inc_i) begin
      count_d  = count_q + CW'(1);
      last_o   = (count_d == target_q);
    end else if (clear_i) begin
      count_d  = '0;
    end
  end

  // Count and target registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      target_q <= '0;
    end else begin
      count_q  <= count_d;
      target_q <= target_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sum_accumulator.sv
// Accumulates a programmable number of unsigned adder sums into one frame
// total, presented with its sample count and a sticky overflow flag.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int unsigned SUM_WIDTH = SUM_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [SUM_WIDTH-1:0] in_sum,
  output logic                 in_ready,
  input  logic [LEN_WIDTH-1:0] frame_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [LEN_WIDTH:0]   out_count,
  output logic                 out_overflow
);

  localparam int unsigned AW1 = ACC_WIDTH + 1;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 accept;
  logic                 frame_start;
  logic                 start;
  logic                 inc;
  logic                 clear;
  logic                 last;
  logic [LEN_WIDTH:0]   count;

  frame_counter #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_frame_counter (
    .clk    (clk),
    .reset  (reset),
    .start_i(start),
    .inc_i  (inc),
    .clear_i(clear),
    .len_i  (frame_len),
    .count_o(count),
    .last_o (last)
  );

  // Handshake decode, accumulate datapath and next-state logic.
  always_comb begin
    in_ready = !reset && ((state_q == ACCUM) || out_ready);
    accept   = in_valid && in_ready;
    // Any accept while holding a result begins a new frame; in ACCUM a
    // zero count marks the start of a frame.
    frame_start = (state_q == HOLD) || (count == '0);
    start    = accept && frame_start;
    inc      = accept && !frame_start;
    // A result taken with no new sample leaves an empty frame behind.
    clear    = (state_q == HOLD) && out_ready && !accept;
    sum_ext  = {1'b0, acc_q} + AW1'(in_sum);

    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (start) begin
      acc_d = ACC_WIDTH'(in_sum);
      ovf_d = 1'b0;
    end else if (inc) begin
      acc_d = sum_ext[ACC_WIDTH-1:0];
      ovf_d = ovf_q | sum_ext[ACC_WIDTH];
    end

    state_d = state_q;
    unique case (state_q)
      ACCUM: if (accept && last) state_d = HOLD;
      HOLD:  if (out_ready) state_d = (accept && last) ? HOLD : ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // State, accumulator and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid    = (state_q == HOLD) && !reset;
  assign out_acc      = acc_q;
  assign out_count    = count;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed, table-driven bench for sum_accumulator.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [60:0] in_sum;
  logic        in_ready;
  logic [7:0]  frame_len;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_acc;
  logic [8:0]  out_count;
  logic        out_overflow;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  sum_accumulator #(
    .SUM_WIDTH(61),
    .ACC_WIDTH(64),
    .LEN_WIDTH(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_sum      (in_sum),
    .in_ready    (in_ready),
    .frame_len   (frame_len),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_acc     (out_acc),
    .out_count   (out_count),
    .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  len;
    int unsigned n;
    logic [60:0] start;
    logic [60:0] step;
    logic [63:0] acc;
    logic [8:0]  cnt;
    logic        ovf;
  } frame_vec_t;

  frame_vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample and wait (bounded) until it is accepted at an edge.
  task automatic send_sample(input logic [60:0] s);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_sum   = s;
    #1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_total++;
      $display("FAIL accept_timeout: in_ready stayed 0 for sample 0x%0h", s);
    end
    tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("rst_in_ready_during", 64'(in_ready), 64'd0);
    chk("rst_out_valid_during", 64'(out_valid), 64'd0);
    tick();
    chk("rst_out_acc", out_acc, 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_overflow", 64'(out_overflow), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready_after", 64'(in_ready), 64'd1);
    chk("rst_out_valid_after", 64'(out_valid), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    frame_len = 8'd4;
    out_ready = 1'b1;

    vecs[0] = '{8'd4,  4,   61'd1, 61'd1, 64'd10, 9'd4, 1'b0};
    vecs[1] = '{8'd16, 16,  61'h1000_0000_0000_0000, 61'd0, 64'd0, 9'd16, 1'b1};
    vecs[2] = '{8'd2,  2,   61'd1, 61'd0, 64'd2, 9'd2, 1'b0};
    vecs[3] = '{8'd0,  256, 61'd1, 61'd0, 64'd256, 9'd256, 1'b0};
    vecs[4] = '{8'd1,  1,   61'd9, 61'd0, 64'd9, 9'd1, 1'b0};
    vecs[5] = '{8'd3,  3,   61'd100, 61'd5, 64'd315, 9'd3, 1'b0};
    vecs[6] = '{8'd2,  2,   61'h1FFF_FFFF_FFFF_FFFF, 61'd0, 64'h3FFF_FFFF_FFFF_FFFE, 9'd2, 1'b0};

    tick();
    do_reset();

    // Table-driven frames, each result taken immediately.
    foreach (vecs[v]) begin
      frame_len = vecs[v].len;
      for (int unsigned k = 0; k < vecs[v].n; k++) begin
        if (k == vecs[v].n - 1 && vecs[v].n > 1)
          chk($sformatf("v%0d_not_valid_early", v), 64'(out_valid), 64'd0);
        send_sample(vecs[v].start + 61'(k) * vecs[v].step);
      end
      in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", v), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_out_acc", v), out_acc, vecs[v].acc);
      chk($sformatf("v%0d_out_count", v), 64'(out_count), 64'(vecs[v].cnt));
      chk($sformatf("v%0d_out_overflow", v), 64'(out_overflow), 64'(vecs[v].ovf));
      tick();
      chk($sformatf("v%0d_taken", v), 64'(out_valid), 64'd0);
    end

    // Back-pressure: result held for 3 cycles with a sample waiting.
    frame_len = 8'd4;
    send_sample(61'd1);
    send_sample(61'd2);
    send_sample(61'd3);
    out_ready = 1'b0;
    send_sample(61'd4);
    frame_len = 8'd2;
    in_sum    = 61'd7;
    in_valid  = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp%0d_in_ready", i), 64'(in_ready), 64'd0);
      chk($sformatf("bp%0d_out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp%0d_out_acc", i), out_acc, 64'd10);
      chk($sformatf("bp%0d_out_count", i), 64'(out_count), 64'd4);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp_next_not_valid", 64'(out_valid), 64'd0);
    chk("bp_next_starts_at_7", out_acc, 64'd7);
    send_sample(61'd8);
    in_valid = 1'b0;
    chk("bp_next_valid", 64'(out_valid), 64'd1);
    chk("bp_next_acc", out_acc, 64'd15);
    chk("bp_next_count", 64'(out_count), 64'd2);
    tick();

    // Zero-bubble single-sample frames: HOLD to HOLD.
    frame_len = 8'd1;
    send_sample(61'd3);
    chk("zb_first_acc", out_acc, 64'd3);
    in_sum = 61'd9;
    #1;
    chk("zb_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("zb_still_valid", 64'(out_valid), 64'd1);
    chk("zb_second_acc", out_acc, 64'd9);
    chk("zb_second_count", 64'(out_count), 64'd1);
    tick();
    chk("zb_taken", 64'(out_valid), 64'd0);

    // Reset mid-frame discards the partial frame.
    frame_len = 8'd8;
    send_sample(61'd50);
    send_sample(61'd60);
    do_reset();
    frame_len = 8'd2;
    send_sample(61'd5);
    send_sample(61'd6);
    in_valid = 1'b0;
    chk("rmf_out_valid", 64'(out_valid), 64'd1);
    chk("rmf_out_acc", out_acc, 64'd11);
    chk("rmf_out_count", 64'(out_count), 64'd2);
    tick();

    // Frame length is latched on the first sample only.
    frame_len = 8'd3;
    send_sample(61'd1);
    frame_len = 8'd1;
    send_sample(61'd2);
    chk("len_latch_not_early", 64'(out_valid), 64'd0);
    send_sample(61'd4);
    in_valid = 1'b0;
    chk("len_latch_valid", 64'(out_valid), 64'd1);
    chk("len_latch_count", 64'(out_count), 64'd3);
    chk("len_latch_acc", out_acc, 64'd7);
    tick();

    // Reset while holding drops the result.
    frame_len = 8'd1;
    out_ready = 1'b0;
    send_sample(61'd5);
    in_valid = 1'b0;
    chk("rh_holding", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the registered wide adder's `sum` output. Accepts a stream of unsigned sums over a valid/ready handshake and accumulates a programmable number of them into one frame total. It presents each total with its sample count and a sticky overflow flag on a valid/ready output port. This gives the adder benchmark a sequential sink that keeps every sum bit live through synthesis.

## Interface
- `SUM_WIDTH`, 61, width of incoming sum (adder width + 1).
- `ACC_WIDTH`, 64, accumulator width; result is modulo 2^ACC_WIDTH.
- `LEN_WIDTH`, 8, width of the frame-length input.
- `clk`  in  1  rising-edge clock; sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream sum valid.
- `in_sum`  in  SUM_WIDTH  unsigned sum from adder.
- `in_ready`  out  1  block accepts `in_sum` this cycle.
- `frame_len`  in  LEN_WIDTH  samples per frame; 0 means 2^LEN_WIDTH.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_acc`  out  ACC_WIDTH  frame total.
- `out_count`  out  LEN_WIDTH+1  samples in frame.
- `out_overflow`  out  1  a carry out of bit ACC_WIDTH-1 occurred during the frame.

## Operation
- Transfer on a port occurs when valid && ready are both high at a rising edge.
- States:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `out_valid`=1, `in_ready`=`out_ready`.
- ACCUM behaviour:
  - Each accept adds zero-extended `in_sum` to the accumulator and increments the count.
  - The first accept of a frame loads the accumulator with `in_sum` directly; it is not added to the stale total. It also latches `frame_len` into an internal target; 0 maps to 2^LEN_WIDTH.
  - `frame_len` changes mid-frame are ignored.
- Carry out of the ACC_WIDTH add sets the sticky overflow bit. The accumulator wraps modulo 2^ACC_WIDTH.
- The accept that makes count equal the target moves the block ACCUM→HOLD. `out_acc`, `out_count`, and `out_overflow` then reflect the completed frame and stay stable while in HOLD.
- HOLD behaviour:
  - Output transfer returns the block to ACCUM.
  - If `in_valid` is high in the same cycle, that sample is accepted as the first sample of the next frame (zero-bubble).
  - A single-sample next frame (target 1) accepted this way goes HOLD→HOLD with the new result.
- Internal count, target, and overflow bit clear at each frame start.
- `in_sum` is treated as unsigned. No sign extension.

## Timing
- Reset, during and in the first cycle after:
  - `out_valid`=0, `out_acc`=0, `out_count`=0, `out_overflow`=0, state ACCUM.
  - `in_ready`=0 while `reset` is high and 1 in the first cycle after.
- Reset mid-frame discards the partial frame. Reset in HOLD drops the unaccepted result.
- Latency: last sample accepted at edge N gives `out_valid`=1 in the cycle after edge N.
- Throughput: one sample per cycle sustained when `out_ready` is high in HOLD.
- With `out_ready` low in HOLD, `in_ready`=0 and outputs are frozen.
- `in_ready` depends combinationally on `out_ready` in HOLD only. `out_valid` has no dependency on `in_valid`.

## Structure
- Package `sum_accumulator_pkg`:
  - state enum (ACCUM, HOLD)
  - default width constants
  - helper function `len_to_target` implementing the 0→2^LEN_WIDTH mapping
- Sub-module `frame_counter`: LEN_WIDTH+1 counter with load/increment, target latch and terminal-count output.
- Top holds the accumulator, overflow bit, and FSM.

## Test plan
- `frame_len`=4, sums 1,2,3,4 on consecutive cycles, `out_ready`=1 → `out_valid` one cycle after the 4th accept, `out_acc`=10, `out_count`=4, `out_overflow`=0.
- Same frame with `out_ready` low 3 cycles, `in_valid` held high with sum 7 → `in_ready`=0 and outputs stable for 3 cycles. When `out_ready` rises, 7 is accepted that cycle and the next frame's `out_acc` starts at 7.
- `frame_len`=16, `in_sum`=2^60 each → `out_acc`=0, `out_overflow`=1. Next frame of 1,1 with `frame_len`=2 → `out_acc`=2, `out_overflow`=0.
- `frame_len`=0, 256 samples of 1 → `out_count`=256, `out_acc`=256.
- `frame_len`=8, reset after 2 accepts, then `frame_len`=2 with sums 5,6 → `out_acc`=11, `out_count`=2.
- `frame_len`=3 latched, changed to 1 after the first accept → frame still completes after 3 samples.
